rr_onehot_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream port between NUM_REQ requesters using a valid/ready handshake. It issues a one-hot grant vector and the equivalent binary index for the downstream mux select. The grant is locked while the downstream port stalls, and the priority pointer rotates only on completed transfers. It sits in front of shared resources such as interconnect ports and the µDMA/TCDM request paths, and instantiates the one-hot-to-binary encoder from common_cells.

---
 rtl/rr_onehot_arbiter_pkg.sv | 10 +
 rtl/onehot_to_bin.sv | 20 ++
 rtl/rr_onehot_arbiter.sv | 117 +++++++++++
 tb/tb_rr_onehot_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared types for the round-robin one-hot arbiter.
package rr_onehot_arbiter_pkg;

  // IDLE searches for a new winner; LOCKED holds the grant across a stall.
  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } arb_state_e;

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary encoder. An all-zero input encodes to zero.
module onehot_to_bin #(
  parameter int unsigned ONEHOT_WIDTH = 8,
  parameter int unsigned BIN_WIDTH    = (ONEHOT_WIDTH > 1) ? $clog2(ONEHOT_WIDTH) : 1
) (
  input  logic [ONEHOT_WIDTH-1:0] onehot_i,
  output logic [BIN_WIDTH-1:0]    bin_o
);

  // OR together the indices of set bits; exact for a one-hot input.
  always_comb begin
    bin_o = '0;
    for (int unsigned i = 0; i < ONEHOT_WIDTH; i++) begin
      if (onehot_i[i]) begin
        bin_o = bin_o | BIN_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with valid/ready downstream handshake. The grant is held
// while the downstream stalls; the priority pointer moves only on a transfer.
module rr_onehot_arbiter
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 8,
  parameter int unsigned IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [NUM_REQ-1:0]   gnt_onehot_o,
  output logic [IDX_WIDTH-1:0] idx_o
);

  localparam int unsigned DblWidth = 2 * NUM_REQ;

  arb_state_e           state_q;
  logic [IDX_WIDTH-1:0] ptr_q;
  logic [NUM_REQ-1:0]   lock_q;

  logic [DblWidth-1:0]  w_req_dbl;
  logic [DblWidth-1:0]  w_pick_dbl;
  logic [NUM_REQ-1:0]   w_req_rot;
  logic [NUM_REQ-1:0]   w_pick_rot;
  logic [NUM_REQ-1:0]   w_cand;
  logic [IDX_WIDTH-1:0] w_ptr_next;
  logic                 w_handshake;

  // Rotate requests right by the pointer so the highest-priority one lands at bit 0.
  assign w_req_dbl = {req_i, req_i} >> ptr_q;
  assign w_req_rot = w_req_dbl[NUM_REQ-1:0];

  // Fixed priority pick: lowest set bit of the rotated vector.
  always_comb begin
    w_pick_rot = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_pick_rot    = '0;
        w_pick_rot[i] = 1'b1;
      end
    end
  end

  // Rotate the pick back left; the upper half of the doubled vector holds the wrap.
  assign w_pick_dbl = {w_pick_rot, w_pick_rot} << ptr_q;
  assign w_cand     = w_pick_dbl[DblWidth-1:NUM_REQ];

  // Outputs: search result in IDLE, held requester in LOCKED (masked when it drops).
  always_comb begin
    valid_o      = 1'b0;
    gnt_onehot_o = '0;
    unique case (state_q)
      StIdle: begin
        valid_o      = |req_i;
        gnt_onehot_o = w_cand;
      end
      StLocked: begin
        valid_o      = |(req_i & lock_q);
        gnt_onehot_o = valid_o ? lock_q : '0;
      end
      default: begin
        valid_o      = 1'b0;
        gnt_onehot_o = '0;
      end
    endcase
  end

  assign w_handshake = valid_o & ready_i;
  assign gnt_o       = gnt_onehot_o & {NUM_REQ{w_handshake}};

  onehot_to_bin #(
    .ONEHOT_WIDTH (NUM_REQ),
    .BIN_WIDTH    (IDX_WIDTH)
  ) u_onehot_to_bin (
    .onehot_i (gnt_onehot_o),
    .bin_o    (idx_o)
  );

  // Pointer wraps at NUM_REQ, not at the power of two of the index width.
  assign w_ptr_next = (idx_o == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : idx_o + IDX_WIDTH'(1);

  // Lock/pointer state machine; a dropped locked request returns to IDLE without a transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      state_q <= StIdle;
      lock_q  <= '0;
    end else begin
      if (w_handshake) begin
        ptr_q <= w_ptr_next;
      end
      unique case (state_q)
        StIdle: begin
          if (valid_o && !ready_i) begin
            state_q <= StLocked;
            lock_q  <= gnt_onehot_o;
          end
        end
        StLocked: begin
          if (w_handshake || !valid_o) begin
            state_q <= StIdle;
            lock_q  <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
          lock_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter: vector table on an 8-requester
// instance plus a short wrap sequence on a 5-requester instance.
module tb_rr_onehot_arbiter;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rdy;
    logic       valid;
    logic [2:0] idx;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] req8;
  logic       rdy8;
  logic [7:0] gnt8;
  logic       valid8;
  logic [7:0] oh8;
  logic [2:0] idx8;

  logic [4:0] req5;
  logic       rdy5;
  logic [4:0] gnt5;
  logic       valid5;
  logic [4:0] oh5;
  logic [2:0] idx5;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  rr_onehot_arbiter #(
    .NUM_REQ (8)
  ) u_dut8 (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req8),
    .gnt_o        (gnt8),
    .valid_o      (valid8),
    .ready_i      (rdy8),
    .gnt_onehot_o (oh8),
    .idx_o        (idx8)
  );

  rr_onehot_arbiter #(
    .NUM_REQ (5)
  ) u_dut5 (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req5),
    .gnt_o        (gnt5),
    .valid_o      (valid5),
    .ready_i      (rdy5),
    .gnt_onehot_o (oh5),
    .idx_o        (idx5)
  );

  task automatic add(input logic r, input logic [7:0] rq, input logic rd,
                     input logic v, input logic [2:0] ix);
    vec_t e;
    e.rst = r; e.req = rq; e.rdy = rd; e.valid = v; e.idx = ix;
    tbl.push_back(e);
  endtask

  // Bundle = {valid, onehot, idx, gnt}
  task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {v,oh,idx,gnt}=%h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [19:0] expect8(input logic v, input logic [2:0] ix, input logic rd);
    logic [7:0] oh;
    oh = v ? (8'h01 << ix) : 8'h00;
    return {v, oh, (v ? ix : 3'd0), ((v && rd) ? oh : 8'h00)};
  endfunction

  function automatic logic [19:0] expect5(input logic v, input logic [2:0] ix, input logic rd);
    logic [4:0] oh;
    oh = v ? (5'b00001 << ix) : 5'b00000;
    return {v, 3'b000, oh, (v ? ix : 3'd0), 3'b000, ((v && rd) ? oh : 5'b00000)};
  endfunction

  task automatic step5(input string name, input logic [4:0] rq, input logic rd,
                       input logic v, input logic [2:0] ix);
    @(negedge clk);
    req5 = rq;
    rdy5 = rd;
    #1;
    check(name, {valid5, 3'b000, oh5, idx5, 3'b000, gnt5}, expect5(v, ix, rd));
  endtask

  initial begin
    rst  = 1'b1;
    req8 = '0; rdy8 = 1'b0;
    req5 = '0; rdy5 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset outputs, idle.
    add(0, 8'h00, 0, 0, 0);
    // Back-to-back rotation with all requests high.
    for (int i = 0; i < 10; i++) add(0, 8'hFF, 1, 1, 3'(i % 8));
    // Grant to 5 -> pointer 6; wrap order 6,7,0,...
    add(0, 8'h20, 1, 1, 5);
    add(0, 8'h05, 1, 1, 0);
    add(0, 8'h04, 1, 1, 2);
    // Stall on requester 0; raising req 1 never preempts.
    add(0, 8'h01, 0, 1, 0);
    add(0, 8'h01, 0, 1, 0);
    add(0, 8'h03, 0, 1, 0);
    add(0, 8'h03, 0, 1, 0);
    add(0, 8'h03, 1, 1, 0);
    add(0, 8'h02, 1, 1, 1);
    // Lock on 3, request dropped: back to IDLE, pointer still 2.
    add(0, 8'h08, 0, 1, 3);
    add(0, 8'h00, 0, 0, 0);
    add(0, 8'h14, 1, 1, 2);
    // Lock on 3, drop coincides with ready: no transfer, pointer still 3.
    add(0, 8'h08, 0, 1, 3);
    add(0, 8'h00, 1, 0, 0);
    add(0, 8'hFF, 1, 1, 3);
    // Lock on 5, then reset mid-lock: pointer back to 0, lock abandoned.
    add(0, 8'h20, 0, 1, 5);
    add(1, 8'h20, 0, 1, 5);
    add(0, 8'hA1, 1, 1, 0);
    add(0, 8'hA0, 1, 1, 5);
    add(0, 8'hA0, 1, 1, 7);
    add(0, 8'h80, 1, 1, 7);

    foreach (tbl[k]) begin
      @(negedge clk);
      rst  = tbl[k].rst;
      req8 = tbl[k].req;
      rdy8 = tbl[k].rdy;
      #1;
      check($sformatf("vec%0d", k), {valid8, oh8, idx8, gnt8},
            expect8(tbl[k].valid, tbl[k].idx, tbl[k].rdy));
    end
    @(negedge clk);
    rst = 1'b0; req8 = '0; rdy8 = 1'b0;

    // Five requesters: pointer wraps from 4 to 0, never to 5.
    step5("n5_top",   5'b10000, 1, 1, 4);
    step5("n5_wrap",  5'b11111, 1, 1, 0);
    step5("n5_next",  5'b11111, 1, 1, 1);
    step5("n5_skip",  5'b10001, 1, 1, 4);
    step5("n5_wrap2", 5'b00011, 1, 1, 0);
    step5("n5_stall", 5'b00110, 0, 1, 1);
    step5("n5_hold",  5'b10110, 0, 1, 1);
    step5("n5_done",  5'b10110, 1, 1, 1);
    step5("n5_after", 5'b10100, 1, 1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
